serial_borrow_subtractor: RTL and testbench
===========================================

Name: serial_borrow_subtractor

Overview:
- Multi-cycle iterative subtractor that computes result = A - B - borrowin over NUMBITS-wide operands.
- Processes SLICEBITS per clock cycle along a registered borrow chain, least-significant slice first.
- Companion to the combinational ripple carry adder in the arithmetic datapath; used where area matters more than latency.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- NUMBITS, 16, operand and result width; must be a multiple of SLICEBITS.
- SLICEBITS, 4, bits subtracted per RUN cycle; 1 <= SLICEBITS <= NUMBITS.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A, B and borrowin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  NUMBITS  minuend, sampled on the accept edge.
- B  input  NUMBITS  subtrahend, sampled on the accept edge.
- borrowin  input  1  borrow into bit 0, sampled on the accept edge.
- out_valid  output  1  result, borrowout and overflow are valid; high only in DONE.
- out_ready  input  1  consumer takes the result.
- result  output NUMBITS  A - B - borrowin, modulo 2^NUMBITS.
- borrowout  output  1  1 iff unsigned A < B + borrowin.
- overflow  output  1  two's-complement overflow: sign(A) != sign(B) and sign(result) != sign(A).

Behaviour:
- Reset (async, active-high): state IDLE, in_ready=1, out_valid=0, result=0, borrowout=0, overflow=0. Slice counter, borrow register and internal accumulators are cleared.
- NUMSLICES = NUMBITS/SLICEBITS.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a rising edge, latch A, B and borrowin into the borrow register; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, subtract slice k of A and B with the registered borrow.
  - Write the slice difference into accumulator slice k, register the slice borrow-out, then k++.
  - On the edge that processes slice NUMSLICES-1, go to DONE. On that same edge, load result from the accumulator, borrowout from the final borrow, and overflow from the MSBs.
- DONE:
  - out_valid=1; result, borrowout and overflow are held stable.
  - When out_ready=1 at a rising edge, go to IDLE. in_ready rises in the next cycle.
- Latency: accept edge e0, slices at edges e1..eNUMSLICES, out_valid high after edge eNUMSLICES. This is NUMSLICES cycles after accept.
- Throughput: one operation per NUMSLICES+2 cycles minimum. No overlap between operations.
- Outputs hold the last completed values through IDLE and RUN until the next completion. out_valid is the only qualifier.
- Input-side rules:
  - in_valid is ignored outside IDLE.
  - A, B and borrowin may change freely after the accept edge.
  - out_ready is ignored outside DONE.
- Arithmetic rules:
  - Slice borrow-out = 1 iff A_slice < B_slice + borrow_in_slice.
  - All arithmetic is unsigned modulo 2^SLICEBITS per slice.
- Case SLICEBITS=NUMBITS: one RUN cycle.
- Reset asserted during RUN or DONE: the in-flight operation is aborted and no out_valid pulse occurs. State returns to IDLE with the reset values above.
- out_valid and out_ready held high continuously: exactly one handshake per operation. The block leaves DONE after one cycle.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Function computing NUMSLICES and counter width ($clog2(NUMSLICES), minimum 1).
- One natural sub-module: slice_subtractor.
  - Combinational, SLICEBITS-wide borrow-ripple.
  - Inputs a, b, bin; outputs diff, bout.
  - Instantiated once and reused each RUN cycle via counter-indexed slice select.

Test Plan (NUMBITS=16, SLICEBITS=4 unless noted):
- A=0x0005, B=0x0003, borrowin=0 -> result=0x0002, borrowout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- A=0x0000, B=0x0001, borrowin=0 -> result=0xFFFF, borrowout=1, overflow=0 (borrow ripples through all 4 slices).
- A=0x8000, B=0x0001, borrowin=0 -> result=0x7FFF, borrowout=0, overflow=1. A=0x1234, B=0x1234, borrowin=1 -> result=0xFFFF, borrowout=1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, result, borrowout and overflow are stable; in_ready=0; toggling in_valid and A has no effect. out_ready=1 -> IDLE and in_ready=1 next cycle.
- Reset pulse during RUN (after 2 slices) -> outputs immediately return to their reset values (out_valid=0, in_ready=1, result=0, borrowout=0, overflow=0); no out_valid pulse. The next operation A=0x00FF, B=0x000F -> result=0x00F0.
- SLICEBITS=16 and SLICEBITS=1 builds: random A, B, borrowin vs a reference model -> results match. Latency is 1 and 16 cycles respectively.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the serial borrow subtractor.
package serial_sub_pkg;

  // Controller states: waiting for operands, iterating slices, holding a result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices the operand is split into
  function automatic int calc_numslices(input int numbits, input int slicebits);
    return numbits / slicebits;
  endfunction

  // Slice counter width; a single-slice build still needs a one-bit counter
  function automatic int calc_ctrwidth(input int numslices);
    return (numslices <= 1) ? 1 : $clog2(numslices);
  endfunction

endpackage

// File: rtl/slice_subtractor.sv
// Combinational borrow-ripple subtractor for one slice: diff = a - b - bin.
module slice_subtractor #(
  parameter int SLICEBITS = 4
) (
  input  logic [SLICEBITS-1:0] a,
  input  logic [SLICEBITS-1:0] b,
  input  logic                 bin,
  output logic [SLICEBITS-1:0] diff,
  output logic                 bout
);

  logic borrow;

  // Ripple the borrow from bit 0 upward, one full-subtractor per bit
  always_comb begin
    diff   = '0;
    borrow = bin;
    for (int i = 0; i < SLICEBITS; i++) begin
      diff[i] = a[i] ^ b[i] ^ borrow;
      borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
    end
    bout = borrow;
  end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Iterative subtractor: result = A - B - borrowin, SLICEBITS per clock,
// least-significant slice first, with valid/ready on both sides.
module serial_borrow_subtractor
  import serial_sub_pkg::*;
#(
  parameter int NUMBITS   = 16,
  parameter int SLICEBITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               borrowin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] result,
  output logic               borrowout,
  output logic               overflow
);

  // NUMBITS is expected to be a whole multiple of SLICEBITS
  localparam int NUMSLICES = calc_numslices(NUMBITS, SLICEBITS);
  localparam int CW        = calc_ctrwidth(NUMSLICES);
  localparam logic [CW-1:0] LASTSLICE = CW'(NUMSLICES - 1);

  state_t               state;
  logic [NUMBITS-1:0]   a_reg;
  logic [NUMBITS-1:0]   b_reg;
  logic [NUMBITS-1:0]   acc;
  logic [NUMBITS-1:0]   next_acc;
  logic [CW-1:0]        ctr;
  logic                 brw;
  logic [SLICEBITS-1:0] a_sl;
  logic [SLICEBITS-1:0] b_sl;
  logic [SLICEBITS-1:0] d_sl;
  logic                 bout_sl;
  logic                 last_slice;
  logic                 next_ovf;

  // Pick the operand slices addressed by the slice counter
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NUMSLICES; k++) begin
      if (ctr == CW'(k)) begin
        a_sl = a_reg[k*SLICEBITS +: SLICEBITS];
        b_sl = b_reg[k*SLICEBITS +: SLICEBITS];
      end
    end
  end

  // One shared slice datapath, reused every RUN cycle
  slice_subtractor #(
    .SLICEBITS(SLICEBITS)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (brw),
    .diff (d_sl),
    .bout (bout_sl)
  );

  // Accumulator with the current slice difference merged in, plus end-of-run flags
  always_comb begin
    next_acc = acc;
    for (int k = 0; k < NUMSLICES; k++) begin
      if (ctr == CW'(k)) begin
        next_acc[k*SLICEBITS +: SLICEBITS] = d_sl;
      end
    end
    last_slice = (ctr == LASTSLICE);
    next_ovf   = (a_reg[NUMBITS-1] != b_reg[NUMBITS-1]) &&
                 (next_acc[NUMBITS-1] != a_reg[NUMBITS-1]);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      ctr       <= '0;
      brw       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            brw      <= borrowin;
            ctr      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= next_acc;
          brw <= bout_sl;
          ctr <= ctr + 1'b1;
          if (last_slice) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= next_acc;
            borrowout <= bout_sl;
            overflow  <= next_ovf;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor: directed table at the
// default 16/4 build, handshake and reset corner cases, plus 16/16 and 16/1 builds.
module tb_serial_borrow_subtractor;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_res;
    logic        exp_bo;
    logic        exp_ov;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        borrowin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        borrowout;
  logic        overflow;

  logic        xvalid;
  logic [15:0] xa;
  logic [15:0] xb;
  logic        xbin;
  logic        x16_in_ready, x16_out_valid, x16_bo, x16_ov;
  logic [15:0] x16_res;
  logic        x1_in_ready, x1_out_valid, x1_bo, x1_ov;
  logic [15:0] x1_res;

  int total;
  int passed;

  serial_borrow_subtractor #(.NUMBITS(16), .SLICEBITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .borrowin(borrowin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .borrowout(borrowout),
    .overflow(overflow)
  );

  serial_borrow_subtractor #(.NUMBITS(16), .SLICEBITS(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(xvalid), .in_ready(x16_in_ready),
    .A(xa), .B(xb), .borrowin(xbin), .out_valid(x16_out_valid),
    .out_ready(1'b1), .result(x16_res), .borrowout(x16_bo),
    .overflow(x16_ov)
  );

  serial_borrow_subtractor #(.NUMBITS(16), .SLICEBITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(xvalid), .in_ready(x1_in_ready),
    .A(xa), .B(xb), .borrowin(xbin), .out_valid(x1_out_valid),
    .out_ready(1'b1), .result(x1_res), .borrowout(x1_bo),
    .overflow(x1_ov)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue one operation on the 16/4 instance and capture the first valid result
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin,
                               output logic [15:0] r, output logic bo, output logic ov,
                               output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    A = a; B = b; borrowin = bin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; borrowin = 1'b1;
    lat = 0;
    r = '0; bo = 1'b0; ov = 1'b0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    r = result; bo = borrowout; ov = overflow;
  endtask

  initial begin
    vec_t        vecs[8];
    logic [15:0] r;
    logic        bo, ov;
    int          lat;
    logic [16:0] ref17;
    logic        ref_ov;
    int          lat16, lat1;
    logic [15:0] r16, r1;
    logic        bo16, ov16, bo1, ov1;
    logic        pulse;

    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    total = 0; passed = 0;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; borrowin = 1'b0; out_ready = 1'b1;
    xvalid = 1'b0; xa = '0; xb = '0; xbin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_borrowout", 32'(borrowout), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, r, bo, ov, lat);
      checkOutput($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_res));
      checkOutput($sformatf("vec%0d_borrowout", i), 32'(bo), 32'(vecs[i].exp_bo));
      checkOutput($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].exp_ov));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_leave_done", i), 32'({in_ready, out_valid}), 32'b10);
    end

    // Backpressure: result held while out_ready stays low
    out_ready = 1'b0;
    applyStimulus(16'h5A5A, 16'h1111, 1'b0, r, bo, ov, lat);
    checkOutput("bp_result", 32'(r), 32'h4949);
    checkOutput("bp_latency", 32'(lat), 32'd4);
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      A = 16'(c * 16'h1357);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d", c),
                  32'({out_valid, in_ready, borrowout, overflow, result}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h4949}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release", 32'({in_ready, out_valid}), 32'b10);

    // Reset in the middle of RUN aborts the operation
    A = 16'h1111; B = 16'h0001; borrowin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs",
                32'({out_valid, in_ready, borrowout, overflow, result}),
                32'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
    @(negedge clk);
    rst = 1'b0;
    pulse = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) pulse = 1'b1;
    end
    checkOutput("abort_no_pulse", 32'(pulse), 32'd0);
    applyStimulus(16'h00FF, 16'h000F, 1'b0, r, bo, ov, lat);
    checkOutput("after_abort_result", 32'(r), 32'h00F0);
    checkOutput("after_abort_flags", 32'({bo, ov}), 32'b00);

    // Single-slice and bit-serial builds against a reference subtraction
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      xa = 16'($urandom);
      xb = 16'($urandom);
      xbin = 1'($urandom_range(0, 1));
      if (v == 0) begin xa = 16'h0000; xb = 16'hFFFF; xbin = 1'b1; end
      xvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      xvalid = 1'b0;
      lat16 = 0; lat1 = 0;
      r16 = '0; bo16 = 1'b0; ov16 = 1'b0; r1 = '0; bo1 = 1'b0; ov1 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (x16_out_valid && lat16 == 0) begin
          lat16 = c; r16 = x16_res; bo16 = x16_bo; ov16 = x16_ov;
        end
        if (x1_out_valid && lat1 == 0) begin
          lat1 = c; r1 = x1_res; bo1 = x1_bo; ov1 = x1_ov;
        end
      end
      ref17  = {1'b0, xa} - {1'b0, xb} - {16'd0, xbin};
      ref_ov = (xa[15] != xb[15]) && (ref17[15] != xa[15]);
      checkOutput($sformatf("s16_v%0d", v), 32'({lat16[7:0], bo16, ov16, r16}),
                  32'({8'd1, ref17[16], ref_ov, ref17[15:0]}));
      checkOutput($sformatf("s1_v%0d", v), 32'({lat1[7:0], bo1, ov1, r1}),
                  32'({8'd16, ref17[16], ref_ov, ref17[15:0]}));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
